fetch_unit: RTL and testbench

- Instruction fetch stage of the 16-bit CPU, directly upstream of the instruction decoder.
- Maintains the fetch PC and issues word reads to instruction memory using a req/ready handshake.
- Holds the fetched word in instruction_reg until the decode/execute side acknowledges it.
- Accepts branch/jump redirects from execute and flushes any in-flight fetch. Exports the PC of the held instruction and the link address (PC+1) used by branch-and-link.

---
 rtl/fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the 16-bit CPU. Keeps the fetch PC, issues word
// reads to instruction memory over a level-held req/ready handshake, and holds
// the fetched word in instruction_reg until the decode/execute side takes it
// with ir_ack. A redirect from execute (taken branch/jump) overrides all
// other activity, drops any in-flight fetch and restarts fetching at
// redirect_addr.
//
// Optional feature (macro FETCH_PREFETCH_EN):
//   When defined, a one-entry prefetch buffer lets the next word be fetched
//   while the current one is still held, giving one instruction per cycle
//   with zero-wait memory. When undefined, the unit fetches one instruction
//   per two cycles at best.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   mem_req         out  fetch request (function of state only)
//   mem_addr        out  word address of the request (always equals fetch PC)
//   mem_ready       in   mem_rdata valid this cycle for mem_addr
//   mem_rdata       in   instruction word from memory
//   instruction_reg out  held instruction for the decoder
//   ir_valid        out  instruction_reg holds a live instruction
//   ir_ack          in   consumer takes instruction_reg this cycle
//   redirect        in   taken branch/jump, highest priority
//   redirect_addr   in   new fetch address
//   ir_pc           out  address of instruction_reg
//   link_addr       out  ir_pc + 1 (wraps), used by branch-and-link
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 11,
  parameter int RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] instruction_reg,
  output logic                 ir_valid,
  input  logic                 ir_ack,
  input  logic                 redirect,
  input  logic [ADDR_SIZE-1:0] redirect_addr,
  output logic [ADDR_SIZE-1:0] ir_pc,
  output logic [ADDR_SIZE-1:0] link_addr
);

  localparam logic [ADDR_SIZE-1:0] RESET_ADDR = ADDR_SIZE'(RESET_PC);
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE   = ADDR_SIZE'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_SIZE-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [WORD_SIZE-1:0]   ir_word_reg, ir_word_next;
  logic [ADDR_SIZE-1:0]   ir_pc_reg, ir_pc_next;
  logic                   ir_valid_reg, ir_valid_next;
  logic [ADDR_SIZE-1:0]   fetch_pc_inc;

`ifdef FETCH_PREFETCH_EN
  logic [WORD_SIZE-1:0]   pf_buf_reg, pf_buf_next;
  logic [ADDR_SIZE-1:0]   pf_pc_reg, pf_pc_next;
  logic                   pf_valid_reg, pf_valid_next;
`endif

  // Sequential fetch address, wraps naturally at 2^ADDR_SIZE.
  assign fetch_pc_inc = fetch_pc_reg + ADDR_ONE;

  assign mem_addr        = fetch_pc_reg;
  assign instruction_reg = ir_word_reg;
  assign ir_valid        = ir_valid_reg;
  assign ir_pc           = ir_pc_reg;
  assign link_addr       = ir_pc_reg + ADDR_ONE;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_ADDR;
      ir_word_reg  <= '0;
      ir_pc_reg    <= '0;
      ir_valid_reg <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_buf_reg   <= '0;
      pf_pc_reg    <= '0;
      pf_valid_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      ir_word_reg  <= ir_word_next;
      ir_pc_reg    <= ir_pc_next;
      ir_valid_reg <= ir_valid_next;
`ifdef FETCH_PREFETCH_EN
      pf_buf_reg   <= pf_buf_next;
      pf_pc_reg    <= pf_pc_next;
      pf_valid_reg <= pf_valid_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Request generation: depends on registered state only, so memory never
  // sees a combinational path from mem_ready or redirect back to mem_req.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req = 1'b0;
    case (state_reg)
      FETCH:   mem_req = 1'b1;
`ifdef FETCH_PREFETCH_EN
      // While holding, fill the empty prefetch slot.
      HOLD:    mem_req = !pf_valid_reg;
`endif
      default: mem_req = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    ir_word_next  = ir_word_reg;
    ir_pc_next    = ir_pc_reg;
    ir_valid_next = ir_valid_reg;
`ifdef FETCH_PREFETCH_EN
    pf_buf_next   = pf_buf_reg;
    pf_pc_next    = pf_pc_reg;
    pf_valid_next = pf_valid_reg;
`endif

    if (redirect) begin
      // Any returning word belongs to the abandoned path: drop it, leave the
      // IR contents alone and just mark them dead. An ir_ack is swallowed.
      fetch_pc_next = redirect_addr;
      ir_valid_next = 1'b0;
      state_next    = FETCH;
`ifdef FETCH_PREFETCH_EN
      pf_valid_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = FETCH;
        end

        FETCH: begin
          if (mem_ready) begin
            ir_word_next  = mem_rdata;
            ir_pc_next    = fetch_pc_reg;
            ir_valid_next = 1'b1;
            fetch_pc_next = fetch_pc_inc;
            state_next    = HOLD;
          end
        end

        HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (ir_ack) begin
            if (pf_valid_reg) begin
              // Promote the buffered word; no request was out this cycle.
              ir_word_next  = pf_buf_reg;
              ir_pc_next    = pf_pc_reg;
              pf_valid_next = 1'b0;
            end else if (mem_ready) begin
              // Word arrives as the old one leaves: bypass the buffer.
              ir_word_next  = mem_rdata;
              ir_pc_next    = fetch_pc_reg;
              fetch_pc_next = fetch_pc_inc;
            end else begin
              ir_valid_next = 1'b0;
              state_next    = FETCH;
            end
          end else if (!pf_valid_reg && mem_ready) begin
            pf_buf_next   = mem_rdata;
            pf_pc_next    = fetch_pc_reg;
            pf_valid_next = 1'b1;
            fetch_pc_next = fetch_pc_inc;
          end
`else
          if (ir_ack) begin
            ir_valid_next = 1'b0;
            state_next    = FETCH;
          end
`endif
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. The memory model returns
// word = address + 0x1000. Expected instructions (word, pc, link) are pushed
// to a scoreboard queue when a scenario is set up and popped whenever the DUT
// hands an instruction over (ir_valid && ir_ack without redirect).
// Build with +define+FETCH_PREFETCH_EN to exercise the prefetch variant.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 11;

`ifdef FETCH_PREFETCH_EN
  localparam int                   EXP_INTERVAL   = 1;
  localparam int                   EXP_HOLD_REQS  = 1;
  localparam logic [WORD_SIZE-1:0] EXP_KEPT_WORD  = 16'h1004;
  localparam logic [ADDR_SIZE-1:0] EXP_KEPT_PC    = 11'h004;
`else
  localparam int                   EXP_INTERVAL   = 2;
  localparam int                   EXP_HOLD_REQS  = 0;
  localparam logic [WORD_SIZE-1:0] EXP_KEPT_WORD  = 16'h1003;
  localparam logic [ADDR_SIZE-1:0] EXP_KEPT_PC    = 11'h003;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 mem_req;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_ready;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic [WORD_SIZE-1:0] instruction_reg;
  logic                 ir_valid;
  logic                 ir_ack;
  logic                 redirect;
  logic [ADDR_SIZE-1:0] redirect_addr;
  logic [ADDR_SIZE-1:0] ir_pc;
  logic [ADDR_SIZE-1:0] link_addr;

  fetch_unit #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .instruction_reg(instruction_reg),
    .ir_valid       (ir_valid),
    .ir_ack         (ir_ack),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .ir_pc          (ir_pc),
    .link_addr      (link_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WORD_SIZE-1:0] word;
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] link;
  } exp_t;

  exp_t sb[$];
  exp_t sb_item;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cycle        = 0;
  bit   popped;
  bit   auto_ready;   // memory answers every request at once
  bit   force_ready;  // answer the current request this cycle
  bit   raw_ready;    // drive mem_ready regardless of mem_req

  // One clock cycle: drive memory response, score any handover, advance.
  task automatic step();
    mem_ready = raw_ready || (mem_req && (auto_ready || force_ready));
    mem_rdata = 16'h1000 + {5'b0, mem_addr};
    popped    = 1'b0;
    if (rst_n && ir_valid && ir_ack && !redirect) begin
      popped = 1'b1;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got word=%h pc=%h, no instruction expected",
                 instruction_reg, ir_pc);
      end else begin
        sb_item = sb.pop_front();
        if (instruction_reg !== sb_item.word || ir_pc !== sb_item.pc ||
            link_addr !== sb_item.link) begin
          tests_failed++;
          $display("FAIL sb_instr: got word=%h pc=%h link=%h, expected word=%h pc=%h link=%h",
                   instruction_reg, ir_pc, link_addr, sb_item.word, sb_item.pc, sb_item.link);
        end else begin
          $display("[TB] cycle %0d instr word=%h pc=%h link=%h", cycle,
                   instruction_reg, ir_pc, link_addr);
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic push_exp(input logic [WORD_SIZE-1:0] w, input logic [ADDR_SIZE-1:0] pc,
                          input logic [ADDR_SIZE-1:0] lk);
    exp_t e;
    e.word = w;
    e.pc   = pc;
    e.link = lk;
    sb.push_back(e);
  endtask

  task automatic run_until_empty(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_timeout: %0d instructions outstanding after %0d cycles, required 0",
               name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || ir_valid !== 1'b0 || mem_addr !== 11'h000 ||
        instruction_reg !== 16'h0000 || ir_pc !== 11'h000 || link_addr !== 11'h001) begin
      tests_failed++;
      $display("FAIL reset_state: req=%b valid=%b addr=%h ir=%h pc=%h link=%h, required 0 0 000 0000 000 001",
               mem_req, ir_valid, mem_addr, instruction_reg, ir_pc, link_addr);
    end
    $display("[TB] reset applied");
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int pop_cyc[3];
    int np = 0;
    int n  = 0;
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_idle_req: mem_req=%b at cycle 0, required 0", mem_req);
    end
    auto_ready = 1'b1;
    ir_ack     = 1'b1;
    push_exp(16'h1000, 11'h000, 11'h001);
    push_exp(16'h1001, 11'h001, 11'h002);
    push_exp(16'h1002, 11'h002, 11'h003);
    step();
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 11'h000) begin
      tests_failed++;
      $display("FAIL stream_first_req: req=%b addr=%h at cycle 1, required 1 000",
               mem_req, mem_addr);
    end
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
      if (popped && np < 3) begin
        pop_cyc[np] = cycle;
        np++;
      end
    end
    tests_run++;
    if (np != 3) begin
      tests_failed++;
      $display("FAIL stream_count: %0d instructions delivered, required 3", np);
      sb.delete();
    end else begin
      tests_run++;
      if (pop_cyc[1] - pop_cyc[0] != EXP_INTERVAL || pop_cyc[2] - pop_cyc[1] != EXP_INTERVAL) begin
        tests_failed++;
        $display("FAIL stream_rate: intervals %0d %0d cycles, required %0d",
                 pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1], EXP_INTERVAL);
      end
    end
    ir_ack = 1'b0;
  endtask

  task automatic test_hold();
    int n    = 0;
    int reqs = 0;
    while (!ir_valid && n < 5) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (mem_req) reqs++;
      step();
      tests_run++;
      if (instruction_reg !== 16'h1003 || ir_pc !== 11'h003 || ir_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_stable: ir=%h pc=%h valid=%b, required 1003 003 1",
                 instruction_reg, ir_pc, ir_valid);
      end
    end
    tests_run++;
    if (reqs != EXP_HOLD_REQS) begin
      tests_failed++;
      $display("FAIL hold_reqs: %0d request cycles while held, required %0d", reqs, EXP_HOLD_REQS);
    end
    $display("[TB] cycle %0d held 0x1003 for 5 cycles, %0d requests", cycle, reqs);
    push_exp(16'h1003, 11'h003, 11'h004);
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL hold_ack: %0d outstanding after ack, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_redirect();
    tests_run++;
    if (mem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL redir_pre_req: mem_req=%b, required 1", mem_req);
    end
    redirect      = 1'b1;
    redirect_addr = 11'h2A0;
    step();  // mem_ready is high in this same cycle
    redirect = 1'b0;
    tests_run++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 11'h2A0) begin
      tests_failed++;
      $display("FAIL redir_flush: valid=%b req=%b addr=%h, required 0 1 2a0",
               ir_valid, mem_req, mem_addr);
    end
    tests_run++;
    if (instruction_reg !== EXP_KEPT_WORD || ir_pc !== EXP_KEPT_PC) begin
      tests_failed++;
      $display("FAIL redir_discard: ir=%h pc=%h, required %h %h",
               instruction_reg, ir_pc, EXP_KEPT_WORD, EXP_KEPT_PC);
    end
    $display("[TB] cycle %0d redirect to 2a0", cycle);
    push_exp(16'h12A0, 11'h2A0, 11'h2A1);
    ir_ack = 1'b1;
    run_until_empty(10, "redir");
  endtask

  task automatic test_wrap();
    redirect      = 1'b1;
    redirect_addr = 11'h7FF;
    step();
    redirect = 1'b0;
    tests_run++;
    if (ir_valid !== 1'b0 || mem_addr !== 11'h7FF) begin
      tests_failed++;
      $display("FAIL wrap_redir: valid=%b addr=%h, required 0 7ff", ir_valid, mem_addr);
    end
    push_exp(16'h17FF, 11'h7FF, 11'h000);
    push_exp(16'h1000, 11'h000, 11'h001);
    run_until_empty(12, "wrap");
    ir_ack = 1'b0;
  endtask

  task automatic test_wait_states();
    auto_ready    = 1'b0;
    redirect      = 1'b1;
    redirect_addr = 11'h100;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 11'h100 || ir_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL wait_hold: req=%b addr=%h valid=%b, required 1 100 0",
                 mem_req, mem_addr, ir_valid);
      end
      step();
    end
    tests_run++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 11'h100) begin
      tests_failed++;
      $display("FAIL wait_pre_ready: valid=%b req=%b addr=%h, required 0 1 100",
               ir_valid, mem_req, mem_addr);
    end
    force_ready = 1'b1;
    step();
    force_ready = 1'b0;
    tests_run++;
    if (ir_valid !== 1'b1 || instruction_reg !== 16'h1100 || ir_pc !== 11'h100) begin
      tests_failed++;
      $display("FAIL wait_load: valid=%b ir=%h pc=%h, required 1 1100 100",
               ir_valid, instruction_reg, ir_pc);
    end
    push_exp(16'h1100, 11'h100, 11'h101);
    auto_ready = 1'b1;
    ir_ack     = 1'b1;
    run_until_empty(10, "wait");
    ir_ack = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    auto_ready    = 1'b0;
    redirect      = 1'b1;
    redirect_addr = 11'h050;
    step();
    redirect = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 11'h050) begin
      tests_failed++;
      $display("FAIL rstmid_pre: req=%b addr=%h, required 1 050", mem_req, mem_addr);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || mem_addr !== 11'h000 || ir_valid !== 1'b0 ||
        instruction_reg !== 16'h0000 || ir_pc !== 11'h000 || link_addr !== 11'h001) begin
      tests_failed++;
      $display("FAIL rstmid_async: req=%b addr=%h valid=%b ir=%h pc=%h link=%h, required 0 000 0 0000 000 001",
               mem_req, mem_addr, ir_valid, instruction_reg, ir_pc, link_addr);
    end
    raw_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    tests_run++;
    if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_idle: req=%b valid=%b, required 0 0", mem_req, ir_valid);
    end
    step();  // IDLE with a stray mem_ready: must be ignored
    raw_ready = 1'b0;
    tests_run++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 11'h000) begin
      tests_failed++;
      $display("FAIL rstmid_restart: valid=%b req=%b addr=%h, required 0 1 000",
               ir_valid, mem_req, mem_addr);
    end
    $display("[TB] cycle %0d restart after mid-fetch reset", cycle);
    push_exp(16'h1000, 11'h000, 11'h001);
    auto_ready = 1'b1;
    ir_ack     = 1'b1;
    run_until_empty(10, "rstmid");
    ir_ack = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    mem_ready     = 1'b0;
    mem_rdata     = '0;
    ir_ack        = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    auto_ready    = 1'b0;
    force_ready   = 1'b0;
    raw_ready     = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_wrap();
    test_wait_states();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
